// File: rtl/conv_pkg.sv
// Shared types and constant helpers for the binary-weight convolution engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        KLATCH,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } conv_state_e;

    // Ceiling log2, floored at 1 so single-entry address spaces still get a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Window/tap/kernel counters and the image and output address arithmetic they imply.
module conv_win_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W    = 28,
    parameter int K        = 5,
    parameter int STRIDE   = 1,
    parameter int NUM_KERN = 6,
    parameter int OUT_W    = 24,
    parameter int OUT_H    = 24,
    parameter int IMG_AW   = 10,
    parameter int OUT_AW   = 12,
    parameter int KERN_AW  = 3,
    parameter int TAP_W    = 5
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_tap_step,
    input  logic               i_win_step,
    output logic [IMG_AW-1:0]  o_img_addr,
    output logic [OUT_AW-1:0]  o_out_addr,
    output logic [KERN_AW-1:0] o_kern,
    output logic [TAP_W-1:0]   o_tap,
    output logic               o_last_tap,
    output logic               o_last_col,
    output logic               o_last_row,
    output logic               o_last_kern
);

    localparam int RW = clog2(K);
    localparam int CW = clog2(OUT_W);
    localparam int HW = clog2(OUT_H);

    logic [TAP_W-1:0]   r_tap;
    logic [RW-1:0]      r_tap_r;
    logic [RW-1:0]      r_tap_c;
    logic [CW-1:0]      r_col;
    logic [HW-1:0]      r_row;
    logic [KERN_AW-1:0] r_kern;
    logic               w_last_tap_c;

    assign w_last_tap_c = (r_tap_c == RW'(K - 1));
    assign o_last_tap   = (r_tap == TAP_W'(K * K - 1));
    assign o_last_col   = (r_col == CW'(OUT_W - 1));
    assign o_last_row   = (r_row == HW'(OUT_H - 1));
    assign o_last_kern  = (r_kern == KERN_AW'(NUM_KERN - 1));

    // Tap position is kept as (row, col) inside the window so no divider is needed.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_tap   <= '0;
            r_tap_r <= '0;
            r_tap_c <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_kern  <= '0;
        end else begin
            if (i_tap_step) begin
                if (o_last_tap) begin
                    r_tap   <= '0;
                    r_tap_r <= '0;
                    r_tap_c <= '0;
                end else begin
                    r_tap <= r_tap + TAP_W'(1);
                    if (w_last_tap_c) begin
                        r_tap_c <= '0;
                        r_tap_r <= r_tap_r + RW'(1);
                    end else begin
                        r_tap_c <= r_tap_c + RW'(1);
                    end
                end
            end
            if (i_win_step) begin
                if (o_last_col) begin
                    r_col <= '0;
                    if (o_last_row) begin
                        r_row  <= '0;
                        r_kern <= o_last_kern ? '0 : r_kern + KERN_AW'(1);
                    end else begin
                        r_row <= r_row + HW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign o_img_addr = IMG_AW'((32'(r_row) * STRIDE + 32'(r_tap_r)) * IMG_W
                                + 32'(r_col) * STRIDE + 32'(r_tap_c));
    assign o_out_addr = OUT_AW'(32'(r_kern) * OUT_H * OUT_W + 32'(r_row) * OUT_W + 32'(r_col));
    assign o_kern     = r_kern;
    assign o_tap      = r_tap;

endmodule

// File: rtl/conv_bin_engine.sv
// Binary-weight KxK convolution over an image RAM, one signed sum and threshold bit per window.
module conv_bin_engine
    import conv_pkg::*;
#(
    parameter int  IMG_W    = 28,
    parameter int  IMG_H    = 28,
    parameter int  K        = 5,
    parameter int  STRIDE   = 1,
    parameter int  PIX_W    = 8,
    parameter int  NUM_KERN = 6,
    localparam int OUT_W    = (IMG_W - K) / STRIDE + 1,
    localparam int OUT_H    = (IMG_H - K) / STRIDE + 1,
    localparam int ACC_W    = PIX_W + clog2(K * K) + 1,
    localparam int IMG_AW   = clog2(IMG_W * IMG_H),
    localparam int KERN_AW  = clog2(NUM_KERN),
    localparam int OUT_AW   = clog2(NUM_KERN * OUT_W * OUT_H)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ACC_W-1:0]   threshold,
    output logic               busy,
    output logic               done,
    output logic [IMG_AW-1:0]  img_addr,
    input  logic [PIX_W-1:0]   img_data,
    output logic [KERN_AW-1:0] kern_addr,
    input  logic [K*K-1:0]     kern_data,
    output logic               out_we,
    output logic [OUT_AW-1:0]  out_addr,
    output logic               out_bit,
    output logic [ACC_W-1:0]   out_sum,
    output logic [2:0]         dbg_state
);

    localparam int TAP_W = clog2(K * K);

    conv_state_e               r_state;
    conv_state_e               w_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   r_thresh;
    logic [K*K-1:0]            r_kern;
    logic [OUT_AW-1:0]         r_out_addr;
    logic signed [ACC_W-1:0]   r_out_sum;
    logic                      r_out_bit;

    logic                      w_accept;
    logic                      w_acc_en;
    logic [TAP_W-1:0]          w_tap;
    logic [TAP_W-1:0]          w_bit_idx;
    logic                      w_last_tap;
    logic                      w_last_col;
    logic                      w_last_row;
    logic                      w_last_kern;
    logic [OUT_AW-1:0]         w_out_addr;
    logic signed [ACC_W-1:0]   w_pix;
    logic signed [ACC_W-1:0]   w_acc_next;

    conv_win_addr_gen #(
        .IMG_W    (IMG_W),
        .K        (K),
        .STRIDE   (STRIDE),
        .NUM_KERN (NUM_KERN),
        .OUT_W    (OUT_W),
        .OUT_H    (OUT_H),
        .IMG_AW   (IMG_AW),
        .OUT_AW   (OUT_AW),
        .KERN_AW  (KERN_AW),
        .TAP_W    (TAP_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_accept),
        .i_tap_step  (r_state == MAC),
        .i_win_step  (r_state == WRITE),
        .o_img_addr  (img_addr),
        .o_out_addr  (w_out_addr),
        .o_kern      (kern_addr),
        .o_tap       (w_tap),
        .o_last_tap  (w_last_tap),
        .o_last_col  (w_last_col),
        .o_last_row  (w_last_row),
        .o_last_kern (w_last_kern)
    );

    assign w_accept = (r_state == IDLE) && start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = KLOAD;
            KLOAD:   w_next = KLATCH;
            KLATCH:  w_next = MAC;
            MAC:     if (w_last_tap) w_next = DRAIN;
            DRAIN:   w_next = WRITE;
            WRITE: begin
                if (w_last_col && w_last_row) w_next = w_last_kern ? DONE : KLOAD;
                else                          w_next = MAC;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Image data lags its address by one cycle: MAC tap t adds tap t-1, DRAIN adds the last tap.
    assign w_acc_en   = ((r_state == MAC) && (w_tap != '0)) || (r_state == DRAIN);
    assign w_bit_idx  = (r_state == DRAIN) ? TAP_W'(K * K - 1) : (w_tap - TAP_W'(1));
    assign w_pix      = $signed(ACC_W'(img_data));
    assign w_acc_next = r_kern[w_bit_idx] ? (r_acc + w_pix) : (r_acc - w_pix);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_thresh   <= '0;
            r_kern     <= '0;
            r_out_addr <= '0;
            r_out_sum  <= '0;
            r_out_bit  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_thresh <= $signed(threshold);
            if (r_state == KLATCH) begin
                r_kern <= kern_data;
                r_acc  <= '0;
            end else if (r_state == WRITE) begin
                r_acc <= '0;
            end else if (w_acc_en) begin
                r_acc <= w_acc_next;
            end
            if (r_state == DRAIN) begin
                r_out_sum  <= w_acc_next;
                r_out_bit  <= (w_acc_next >= r_thresh);
                r_out_addr <= w_out_addr;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_we    = (r_state == WRITE);
    assign out_addr  = r_out_addr;
    assign out_sum   = r_out_sum;
    assign out_bit   = r_out_bit;
    assign dbg_state = r_state;

endmodule

// File: doc/conv_bin_engine.md
Name: conv_bin_engine

Overview:
Parametrised binary-weight 2-D convolution engine, successor to the fixed 28x28 / 5x5 first-layer conv.
For each of NUM_KERN binary kernels it slides a KxK window over a single-channel image in RAM, with configurable stride.
Each output produces a signed sum and a thresholded bit, written to the pooling-stage RAM.
It adds a start/busy/done handshake, synchronous reset, a run-time threshold, and explicit RAM read-latency handling.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
K, 5, kernel side (KxK window)
STRIDE, 1, window step in both directions
PIX_W, 8, unsigned pixel width
NUM_KERN, 6, number of kernels processed per run
Derived (localparam, not overridable):
- OUT_W=(IMG_W-K)/STRIDE+1, OUT_H likewise
- ACC_W=PIX_W+clog2(K*K)+1
- IMG_AW=clog2(IMG_W*IMG_H)
- KERN_AW=clog2(NUM_KERN)
- OUT_AW=clog2(NUM_KERN*OUT_W*OUT_H)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  run request; sampled only in IDLE
threshold  in  ACC_W  signed threshold; sampled at start acceptance
busy  out  1  high from the cycle after start is accepted until DONE inclusive
done  out  1  one-cycle pulse at end of run
img_addr  out  IMG_AW  image RAM read address
img_data  in  PIX_W  image RAM data, valid 1 cycle after img_addr
kern_addr  out  KERN_AW  kernel RAM read address
kern_data  in  K*K  kernel bits, row-major, bit0 = top-left; 1 = +pixel, 0 = -pixel; valid 1 cycle after kern_addr
out_we  out  1  output write strobe
out_addr  out  OUT_AW  address = kern*OUT_H*OUT_W + row*OUT_W + col
out_bit  out  1  1 when sum >= threshold (signed compare)
out_sum  out  ACC_W  signed window sum

Behaviour:
- Reset (synchronous, active-high): state IDLE. busy, done, out_we, out_bit = 0; all addresses and out_sum = 0; accumulator and row/col/kern/tap counters = 0.
- rst mid-run aborts immediately. No further out_we until a new start.
- FSM:
  - IDLE: on start, capture threshold -> KLOAD.
  - KLOAD: drive kern_addr=kern -> KLATCH.
  - KLATCH: register kern_data; clear accumulator -> MAC.
  - MAC: K*K cycles. Tap t drives img_addr=(row*STRIDE+t/K)*IMG_W + col*STRIDE + t%K. From the second MAC cycle on, accumulate the previous tap's data: +img_data if its kernel bit is 1, else -img_data. Sign-extend to ACC_W. -> DRAIN.
  - DRAIN: accumulate the last tap -> WRITE.
  - WRITE: out_we=1 for exactly one cycle with out_addr, out_bit and out_sum. Then advance col; on col wrap advance row; on row wrap advance kern. Next state is MAC for a new window, KLOAD for a new kernel, or DONE after the last kernel.
  - DONE: done=1 for one cycle -> IDLE.
- Timing: each output takes K*K+2 cycles. Each kernel takes 2+OUT_W*OUT_H*(K*K+2) cycles. done asserts NUM_KERN*(2+OUT_W*OUT_H*(K*K+2))+1 cycles after the start-accept cycle.
- Outputs are written in increasing out_addr order with no gaps or repeats.
- start while busy is ignored. start coincident with DONE is ignored; it is re-sampled in IDLE.
- Accumulator cannot overflow by construction (ACC_W sized for K*K*(2^PIX_W-1) magnitude).
- out_bit, out_sum and out_addr hold their values between writes; consumers must qualify them with out_we.
- Threshold is frozen for the whole run. Changes while busy have no effect.

Decomposition:
- Shared package conv_pkg holds the state enum (IDLE, KLOAD, KLATCH, MAC, DRAIN, WRITE, DONE) and a clog2 constant function.
- One natural sub-module: conv_win_addr_gen. It holds the tap, col, row and kern counters and produces img_addr, out_addr and the last-tap / last-col / last-row / last-kern flags. The top level holds the FSM and accumulator.

Test Plan:
- Parameters IMG 5x5, K=3, NUM_KERN=1; all pixels 10, kernel all ones, threshold 0 -> 9 writes at addr 0..8, each out_sum=90, out_bit=1; done exactly 102 cycles after start accept.
- Same setup, kernel all zeros -> every out_sum=-90, out_bit=0; threshold=-90 -> every out_bit=1 (equality boundary).
- Defaults (28x28, K=5, 6 kernels), pixels ramp p=addr%256, random kernels -> 3456 writes. Each out_sum matches the reference model, and out_addr runs 0..3455 in order.
- STRIDE=2, IMG 7x7, K=3 -> OUT 3x3. Window (1,2) reads img_addr base 2*7+4=18 first tap; 9 writes.
- Assert rst during the 50th MAC cycle -> next cycle busy=0, no out_we. A new start reruns from out_addr 0 with correct sums.
- Pulse start during busy and on the DONE cycle -> ignored. Write count is unchanged and one done pulse occurs per accepted run.
